// File: rtl/sub_rbs_serial.sv
// Serial ripple-borrow subtractor: diff = a - b - b_in, one SLICE-bit slice per clock, LSB first.
// Optional signed-overflow flag is built only when SUB_RBS_SERIAL_OVF_EN is defined.
module sub_rbs_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int unsigned NS       = WIDTH / SLICE;
  localparam int unsigned KW       = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned SW       = SLICE + 1;
  localparam int unsigned SHIFT_UP = WIDTH - SLICE;
  localparam logic [KW-1:0] K_LAST = KW'(NS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_w_q, a_w_d;
  logic [WIDTH-1:0] b_w_q, b_w_d;
  logic [WIDTH-1:0] wdiff_q, wdiff_d;
  logic             brw_q, brw_d;
  logic             busy_d, done_d, b_out_d;
  logic [WIDTH-1:0] diff_d;
  logic [SW-1:0]    slice_full;

`ifdef SUB_RBS_SERIAL_OVF_EN
  logic a_sign_q, a_sign_d;
  logic b_sign_q, b_sign_d;
  logic ovf_d;
`endif

  // Working operands shift right each cycle, so the current slice is always the low SLICE bits.
  always_comb begin
    slice_full = {1'b0, a_w_q[SLICE-1:0]} - {1'b0, b_w_q[SLICE-1:0]} - SW'(brw_q);
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_w_d   = a_w_q;
    b_w_d   = b_w_q;
    wdiff_d = wdiff_q;
    brw_d   = brw_q;
    done_d  = 1'b0;
    diff_d  = diff;
    b_out_d = b_out;
`ifdef SUB_RBS_SERIAL_OVF_EN
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    ovf_d    = ovf;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_w_d   = a;
          b_w_d   = b;
          brw_d   = b_in;
          wdiff_d = '0;
          k_d     = '0;
          state_d = RUN;
`ifdef SUB_RBS_SERIAL_OVF_EN
          a_sign_d = a[WIDTH-1];
          b_sign_d = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_w_d   = a_w_q >> SLICE;
        b_w_d   = b_w_q >> SLICE;
        brw_d   = slice_full[SLICE];
        // New slice enters at the top; after NS slices the LSB slice has reached bit 0.
        wdiff_d = (wdiff_q >> SLICE) | (WIDTH'(slice_full[SLICE-1:0]) << SHIFT_UP);
        k_d     = k_q + KW'(1);
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = IDLE;
          done_d  = 1'b1;
          diff_d  = wdiff_d;
          b_out_d = slice_full[SLICE];
`ifdef SUB_RBS_SERIAL_OVF_EN
          ovf_d   = (a_sign_q != b_sign_q) && (wdiff_d[WIDTH-1] != a_sign_q);
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_w_q   <= '0;
      b_w_q   <= '0;
      wdiff_q <= '0;
      brw_q   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      b_out   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_w_q   <= a_w_d;
      b_w_q   <= b_w_d;
      wdiff_q <= wdiff_d;
      brw_q   <= brw_d;
      busy    <= busy_d;
      done    <= done_d;
      diff    <= diff_d;
      b_out   <= b_out_d;
    end
  end

`ifdef SUB_RBS_SERIAL_OVF_EN
  // Overflow flag and latched operand signs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      ovf      <= ovf_d;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
